// File: rtl/gold_seq_ctrl_if.sv
// Control bundle between the Gold-code sequencer and its requester / branch registers.
// Master drives the request side; slave is the sequencer.
interface gold_seq_ctrl_if #(
  parameter int unsigned FILL_LEN = 26,
  parameter int unsigned CNT_W    = 16
);
  logic                Start;
  logic [FILL_LEN-1:0] Seed_A;
  logic [FILL_LEN-1:0] Seed_B;
  logic [CNT_W-1:0]    Seq_Len;
  logic                Stall;

  logic                Enable;
  logic                Fill_En_A;
  logic                New_Fill_A;
  logic                Fill_En_B;
  logic                New_Fill_B;
  logic                Chip_Valid;
  logic                Busy;
  logic                Done;

  modport master (
    output Start, Seed_A, Seed_B, Seq_Len, Stall,
    input  Enable, Fill_En_A, New_Fill_A, Fill_En_B, New_Fill_B, Chip_Valid, Busy, Done
  );

  modport slave (
    input  Start, Seed_A, Seed_B, Seq_Len, Stall,
    output Enable, Fill_En_A, New_Fill_A, Fill_En_B, New_Fill_B, Chip_Valid, Busy, Done
  );
endinterface

// File: rtl/gold_seq_ctrl.sv
// Sequencer for a two-branch Gold-code generator: serially fills both branch registers from
// captured seeds (MSB first), then runs them for a programmed number of chips with stall support.
module gold_seq_ctrl #(
  parameter int unsigned FILL_LEN = 26,
  parameter int unsigned CNT_W    = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  gold_seq_ctrl_if.slave bus
);

  localparam int unsigned FillW = (FILL_LEN > 1) ? $clog2(FILL_LEN) : 1;
  localparam logic [FillW-1:0] FillLast = FillW'(FILL_LEN - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFill = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [FillW-1:0]    fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]    chip_cnt_q, chip_cnt_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [FILL_LEN-1:0] seed_a_q, seed_a_d;
  logic [FILL_LEN-1:0] seed_b_q, seed_b_d;

  logic fill_last;
  logic chip_last;

  assign fill_last = (fill_cnt_q == FillLast);
  // Only evaluated in RUN, where len_q is known to be non-zero.
  assign chip_last = (chip_cnt_q == (len_q - CNT_W'(1)));

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    chip_cnt_d = chip_cnt_q;
    len_d      = len_q;
    seed_a_d   = seed_a_q;
    seed_b_d   = seed_b_q;

    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          state_d    = StFill;
          seed_a_d   = bus.Seed_A;
          seed_b_d   = bus.Seed_B;
          len_d      = bus.Seq_Len;
          fill_cnt_d = '0;
          chip_cnt_d = '0;
        end
      end

      StFill: begin
        // The MSB is presented on New_Fill each cycle, so shift the copy left.
        seed_a_d = {seed_a_q[FILL_LEN-2:0], 1'b0};
        seed_b_d = {seed_b_q[FILL_LEN-2:0], 1'b0};
        if (fill_last) begin
          fill_cnt_d = '0;
          chip_cnt_d = '0;
          state_d    = (len_q == '0) ? StDone : StRun;
        end else begin
          fill_cnt_d = fill_cnt_q + FillW'(1);
        end
      end

      StRun: begin
        if (!bus.Stall) begin
          if (chip_last) begin
            chip_cnt_d = '0;
            state_d    = StDone;
          end else begin
            chip_cnt_d = chip_cnt_q + CNT_W'(1);
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= StIdle;
      fill_cnt_q <= '0;
      chip_cnt_q <= '0;
      len_q      <= '0;
      seed_a_q   <= '0;
      seed_b_q   <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      chip_cnt_q <= chip_cnt_d;
      len_q      <= len_d;
      seed_a_q   <= seed_a_d;
      seed_b_q   <= seed_b_d;
    end
  end

  // Outputs: Stall -> Enable/Chip_Valid in RUN are the only combinational input paths.
  always_comb begin
    bus.Enable     = 1'b0;
    bus.Fill_En_A  = 1'b0;
    bus.New_Fill_A = 1'b0;
    bus.Fill_En_B  = 1'b0;
    bus.New_Fill_B = 1'b0;
    bus.Chip_Valid = 1'b0;
    bus.Busy       = 1'b0;
    bus.Done       = 1'b0;

    unique case (state_q)
      StIdle: begin
      end

      StFill: begin
        bus.Enable     = 1'b1;
        bus.Fill_En_A  = 1'b1;
        bus.Fill_En_B  = 1'b1;
        bus.New_Fill_A = seed_a_q[FILL_LEN-1];
        bus.New_Fill_B = seed_b_q[FILL_LEN-1];
        bus.Busy       = 1'b1;
      end

      StRun: begin
        bus.Enable     = !bus.Stall;
        bus.Chip_Valid = !bus.Stall;
        bus.Busy       = 1'b1;
      end

      StDone: begin
        bus.Done = 1'b1;
        bus.Busy = 1'b1;
      end

      default: begin
      end
    endcase
  end

  fill_cnt_in_range_a: assert property (@(posedge Clock) disable iff (Reset)
    (state_q == StFill) |-> (fill_cnt_q <= FillLast));

  chip_cnt_in_range_a: assert property (@(posedge Clock) disable iff (Reset)
    (state_q == StRun) |-> (chip_cnt_q < len_q));

  done_one_cycle_a: assert property (@(posedge Clock) disable iff (Reset)
    bus.Done |=> !bus.Done);

  done_implies_busy_a: assert property (@(posedge Clock) disable iff (Reset)
    bus.Done |-> bus.Busy);

endmodule

// File: tb/tb_gold_seq_ctrl.sv
// Bench for gold_seq_ctrl: table of sequences plus reset corner cases; a model of the two
// branch registers is driven by the DUT outputs and its chips are scoreboarded against a golden LFSR.
module tb_gold_seq_ctrl;

  localparam int FillLen = 26;
  localparam int CntW    = 16;

  logic clk;
  logic rst;

  gold_seq_ctrl_if #(.FILL_LEN(FillLen), .CNT_W(CntW)) bus ();

  gold_seq_ctrl #(.FILL_LEN(FillLen), .CNT_W(CntW)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] seed_a;
    logic [25:0] seed_b;
    logic [15:0] len;
    logic [31:0] stall_mask;
    bit          poke;
    int          exp_chips;
    int          exp_done;
  } vec_t;

  vec_t vecs[5];
  vec_t big;
  int   checks;
  int   errors;
  logic sb[$];

  // Branch models: A is 18 stages (keeps the last 18 fill bits), B is 26 stages.
  logic [17:0] ra;
  logic [25:0] rb;

  function automatic logic [17:0] step_a(input logic [17:0] r);
    return {r[16:0], r[17] ^ r[6]};
  endfunction

  function automatic logic [25:0] step_b(input logic [25:0] r);
    return {r[24:0], r[25] ^ r[2] ^ r[1] ^ r[0]};
  endfunction

  always_ff @(posedge clk) begin
    if (bus.Enable) begin
      ra <= bus.Fill_En_A ? {ra[16:0], bus.New_Fill_A} : step_a(ra);
      rb <= bus.Fill_En_B ? {rb[24:0], bus.New_Fill_B} : step_b(rb);
    end
  end

  function automatic logic [7:0] outs();
    return {bus.Enable, bus.Fill_En_A, bus.New_Fill_A, bus.Fill_En_B, bus.New_Fill_B,
            bus.Chip_Valid, bus.Busy, bus.Done};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_seq(input vec_t v);
    int          chips;
    int          r;
    logic [17:0] ga;
    logic [25:0] gb;
    logic        stl;
    ga = v.seed_a[17:0];
    gb = v.seed_b;
    sb.delete();
    for (int j = 0; j < int'(v.len); j++) begin
      sb.push_back(ga[17] ^ gb[25]);
      ga = step_a(ga);
      gb = step_b(gb);
    end
    chips = 0;

    @(negedge clk);
    bus.Start   = 1'b1;
    bus.Seed_A  = v.seed_a;
    bus.Seed_B  = v.seed_b;
    bus.Seq_Len = v.len;
    bus.Stall   = 1'b0;
    #1 check("idle_outs", 64'(outs()), 64'h0);
    @(negedge clk);
    bus.Start = 1'b0;

    for (int cyc = 0; cyc <= v.exp_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      r = cyc - FillLen;
      if (r < 0) stl = v.poke && cyc[2];
      else stl = (r < 32) ? v.stall_mask[r] : 1'b0;
      bus.Stall = stl;
      if (v.poke && (cyc == 5 || cyc == FillLen + 2 || cyc == v.exp_done)) begin
        bus.Start   = 1'b1;
        bus.Seed_A  = ~v.seed_a;
        bus.Seed_B  = ~v.seed_b;
        bus.Seq_Len = v.len + 16'd7;
      end else begin
        bus.Start   = 1'b0;
        bus.Seed_A  = v.seed_a;
        bus.Seed_B  = v.seed_b;
        bus.Seq_Len = v.len;
      end
      #1;
      if (cyc == FillLen) begin
        check("branch_a_fill", 64'(ra), 64'(v.seed_a[17:0]));
        check("branch_b_fill", 64'(rb), 64'(v.seed_b));
      end
      if (cyc < FillLen) begin
        check("fill_ctl", 64'({bus.Enable, bus.Fill_En_A, bus.Fill_En_B, bus.Chip_Valid,
                               bus.Busy, bus.Done}), 64'(6'b111010));
        check("new_fill_a", 64'(bus.New_Fill_A), 64'(v.seed_a[FillLen-1-cyc]));
        check("new_fill_b", 64'(bus.New_Fill_B), 64'(v.seed_b[FillLen-1-cyc]));
      end else if (cyc < v.exp_done) begin
        check("run_ctl", 64'(outs()), 64'({!stl, 4'b0000, !stl, 2'b10}));
      end else begin
        check("done_outs", 64'(outs()), 64'h03);
      end
      if (bus.Chip_Valid) begin
        chips++;
        if (sb.size() == 0) check("chip_extra", 64'd1, 64'd0);
        else check("chip", 64'(ra[17] ^ rb[25]), 64'(sb.pop_front()));
      end
    end
    check("chip_count", 64'(chips), 64'(v.exp_chips));
    check("sb_empty", 64'(sb.size()), 64'd0);
    bus.Start = 1'b0;
    bus.Stall = 1'b0;
  endtask

  task automatic reset_mid(input int at_cyc);
    @(negedge clk);
    bus.Start   = 1'b1;
    bus.Seed_A  = 26'h155AA33;
    bus.Seed_B  = 26'h0C3C3C3;
    bus.Seq_Len = 16'd10;
    bus.Stall   = 1'b0;
    @(negedge clk);
    bus.Start = 1'b0;
    for (int c = 0; c < at_cyc; c++) @(negedge clk);
    #1;
    if (at_cyc < FillLen) check("pre_reset_fill", 64'(bus.Fill_En_A), 64'd1);
    else check("pre_reset_chip", 64'(bus.Chip_Valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_reset_outs", 64'(outs()), 64'h0);
    @(negedge clk);
    #1 check("post_reset_idle", 64'(outs()), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{26'h2AAAAAA, 26'h3000001, 16'd5, 32'h0, 1'b0, 5, 31};
    vecs[1] = '{26'h1234567, 26'h0ABCDEF, 16'd0, 32'h0, 1'b0, 0, 26};
    vecs[2] = '{26'h3FFFFFF, 26'h1555555, 16'd4, 32'hC, 1'b0, 4, 32};
    vecs[3] = '{26'h0F0F0F0, 26'h2468ACE, 16'd3, 32'h0, 1'b1, 3, 29};
    vecs[4] = '{26'h0000001, 26'h2000000, 16'd1, 32'h0, 1'b0, 1, 27};
    big     = '{26'h1C0FFEE, 26'h2BADCAF, 16'hFFFF, 32'h0, 1'b0, 65535, FillLen + 65535};

    rst         = 1'b1;
    bus.Start   = 1'b0;
    bus.Seed_A  = '0;
    bus.Seed_B  = '0;
    bus.Seq_Len = '0;
    bus.Stall   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("reset_outs", 64'(outs()), 64'h0);

    for (int i = 0; i < 5; i++) run_seq(vecs[i]);

    reset_mid(10);
    reset_mid(FillLen + 3);
    run_seq(vecs[0]);
    run_seq(big);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
